// File: rtl/tcdm_amo_pkg.sv
// Shared types for the TCDM atomic shim: the AMO opcode set and the lane width.
package tcdm_amo_pkg;

  localparam int unsigned LANE_W = 32;

  typedef enum logic [3:0] {
    AMO_NONE = 4'h0,
    AMO_SWAP = 4'h1,
    AMO_ADD  = 4'h2,
    AMO_AND  = 4'h3,
    AMO_OR   = 4'h4,
    AMO_XOR  = 4'h5,
    AMO_MAX  = 4'h6,
    AMO_MAXU = 4'h7,
    AMO_MIN  = 4'h8,
    AMO_MINU = 4'h9,
    AMO_CAS  = 4'hA,
    AMO_LR   = 4'hB,
    AMO_SC   = 4'hC
  } amo_op_t;

  // Undefined encodings D-F behave as plain accesses.
  function automatic amo_op_t decode_op(input logic [3:0] raw);
    return (raw > 4'hC) ? AMO_NONE : amo_op_t'(raw);
  endfunction

endpackage

// File: rtl/tcdm_amo_lrsc_shim_if.sv
// Bundle of interconnect-side and SRAM-side signals of the atomic shim.
interface tcdm_amo_lrsc_shim_if #(
  parameter int unsigned AddrMemWidth = 32,
  parameter int unsigned DataWidth    = 64,
  parameter int unsigned NumCores     = 8
);
  localparam int unsigned IdWidth = (NumCores > 1) ? $clog2(NumCores) : 1;
  localparam int unsigned BeWidth = DataWidth / 8;

  // Handshake: a request transfers on a clock edge where in_req_i and in_gnt_o are both
  // high; in_rvalid_o pulses exactly one cycle later carrying in_rid_o/in_rdata_o.
  // out_req_o has no back-pressure; SRAM read data appears one cycle after a read.
  logic                    in_req_i;
  logic                    in_gnt_o;
  logic [AddrMemWidth-1:0] in_add_i;
  logic [3:0]              in_amo_i;
  logic                    in_wen_i;
  logic [DataWidth-1:0]    in_wdata_i;
  logic [BeWidth-1:0]      in_be_i;
  logic [IdWidth-1:0]      in_id_i;
  logic                    in_rvalid_o;
  logic [IdWidth-1:0]      in_rid_o;
  logic [DataWidth-1:0]    in_rdata_o;
  logic                    out_req_o;
  logic [AddrMemWidth-1:0] out_add_o;
  logic                    out_wen_o;
  logic [DataWidth-1:0]    out_wdata_o;
  logic [BeWidth-1:0]      out_be_o;
  logic [DataWidth-1:0]    out_rdata_i;
  logic                    dbg_state_o;

  modport slave (
    input  in_req_i, in_add_i, in_amo_i, in_wen_i, in_wdata_i, in_be_i, in_id_i, out_rdata_i,
    output in_gnt_o, in_rvalid_o, in_rid_o, in_rdata_o,
    output out_req_o, out_add_o, out_wen_o, out_wdata_o, out_be_o, dbg_state_o
  );

  modport master (
    output in_req_i, in_add_i, in_amo_i, in_wen_i, in_wdata_i, in_be_i, in_id_i, out_rdata_i,
    input  in_gnt_o, in_rvalid_o, in_rid_o, in_rdata_o,
    input  out_req_o, out_add_o, out_wen_o, out_wdata_o, out_be_o, dbg_state_o
  );
endinterface

// File: rtl/tcdm_amo_alu.sv
// Combinational 32-bit AMO ALU; one shared 33-bit adder serves add and all compares.
module tcdm_amo_alu
  import tcdm_amo_pkg::*;
(
  input  amo_op_t     op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] swap_i,
  output logic [31:0] res_o
);
  logic        is_sub;
  logic        is_sgn;
  logic [32:0] sum;
  logic        a_lt_b;

  always_comb begin
    is_sub = (op_i == AMO_MAX) || (op_i == AMO_MAXU) || (op_i == AMO_MIN) || (op_i == AMO_MINU);
    is_sgn = (op_i == AMO_MAX) || (op_i == AMO_MIN);
    // Extending by the sign (signed) or zero (unsigned) makes bit 32 the borrow of a-b.
    sum    = {is_sgn & a_i[31], a_i} + ({is_sgn & b_i[31], b_i} ^ {33{is_sub}}) + {32'b0, is_sub};
    a_lt_b = sum[32];
    res_o  = a_i;
    case (op_i)
      AMO_SWAP:            res_o = b_i;
      AMO_ADD:             res_o = sum[31:0];
      AMO_AND:             res_o = a_i & b_i;
      AMO_OR:              res_o = a_i | b_i;
      AMO_XOR:             res_o = a_i ^ b_i;
      AMO_MAX,  AMO_MAXU:  res_o = a_lt_b ? b_i : a_i;
      AMO_MIN,  AMO_MINU:  res_o = a_lt_b ? a_i : b_i;
      AMO_CAS:             res_o = (a_i == b_i) ? swap_i : a_i;
      default:             res_o = a_i;
    endcase
  end
endmodule

// File: rtl/tcdm_amo_lrsc_shim.sv
// Per-bank atomic shim: AMO read-modify-write on one 32-bit lane, LR/SC reservations per core.
module tcdm_amo_lrsc_shim
  import tcdm_amo_pkg::*;
#(
  parameter int unsigned AddrMemWidth = 32,
  parameter int unsigned DataWidth    = 64,
  parameter int unsigned NumCores     = 8
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  tcdm_amo_lrsc_shim_if.slave bus
);
  localparam int unsigned Lanes    = DataWidth / LANE_W;
  localparam int unsigned LaneIdxW = (Lanes > 1) ? $clog2(Lanes) : 1;
  localparam int unsigned IdWidth  = (NumCores > 1) ? $clog2(NumCores) : 1;
  localparam int unsigned NumResv  = 1 << IdWidth;
  localparam int unsigned BeW      = DataWidth / 8;

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StDoAmo = 1'b1;
  localparam logic [1:0] RespConst = 2'd0;
  localparam logic [1:0] RespLoad  = 2'd1;
  localparam logic [1:0] RespAmo   = 2'd2;

  if ((DataWidth % LANE_W) != 0 || DataWidth < 32 || DataWidth > 256) begin : g_bad_width
    $fatal(1, "DataWidth must be a multiple of 32 in 32..256");
  end
  // CAS takes its swap operand from the neighbouring lane, which a single-lane bank lacks.
  if (Lanes == 1) begin : g_no_cas_lane
    $fatal(1, "CAS needs at least two 32-bit lanes");
  end

  typedef logic [LaneIdxW-1:0] lane_t;

  function automatic logic [BeW-1:0] lane_be(input lane_t l);
    logic [BeW-1:0] be;
    be = '0;
    for (int unsigned i = 0; i < Lanes; i++) if (lane_t'(i) == l) be[i*4 +: 4] = 4'hF;
    return be;
  endfunction

  function automatic logic [DataWidth-1:0] lane_place(input lane_t l, input logic [31:0] v);
    logic [DataWidth-1:0] d;
    d = '0;
    for (int unsigned i = 0; i < Lanes; i++) if (lane_t'(i) == l) d[i*LANE_W +: LANE_W] = v;
    return d;
  endfunction

  logic [0:0]              state_q, state_d;
  amo_op_t                 op_q, op_d;
  logic [AddrMemWidth-1:0] addr_q, addr_d;
  lane_t                   lane_q, lane_d;
  logic [31:0]             b_q, b_d, swap_q, swap_d;
  logic                    rvalid_q, rvalid_d;
  logic [IdWidth-1:0]      rid_q, rid_d;
  logic [1:0]              resp_sel_q, resp_sel_d;
  logic [DataWidth-1:0]    resp_data_q, resp_data_d;
  logic [NumResv-1:0]      res_valid_q, res_valid_d;
  logic [AddrMemWidth-1:0] res_addr_q [NumResv];
  logic [AddrMemWidth-1:0] res_addr_d [NumResv];

  amo_op_t                 in_op;
  lane_t                   in_lane;
  logic                    lane_found;
  logic [31:0]             in_b, in_swap, old_a, alu_res;
  logic                    sc_ok, wr_valid;
  logic [AddrMemWidth-1:0] wr_addr;

  always_comb begin
    in_op      = decode_op(bus.in_amo_i);
    in_lane    = '0;
    lane_found = 1'b0;
    in_b       = '0;
    in_swap    = '0;
    old_a      = '0;
    for (int unsigned i = 0; i < Lanes; i++) begin
      if (!lane_found && (|bus.in_be_i[i*4 +: 4])) begin
        in_lane    = lane_t'(i);
        lane_found = 1'b1;
      end
    end
    for (int unsigned i = 0; i < Lanes; i++) begin
      if (lane_t'(i) == in_lane)              in_b    = bus.in_wdata_i[i*LANE_W +: LANE_W];
      if (lane_t'(i) == (in_lane ^ lane_t'(1))) in_swap = bus.in_wdata_i[i*LANE_W +: LANE_W];
      if (lane_t'(i) == lane_q)               old_a   = bus.out_rdata_i[i*LANE_W +: LANE_W];
    end
    sc_ok = res_valid_q[bus.in_id_i] && (res_addr_q[bus.in_id_i] == bus.in_add_i);
  end

  tcdm_amo_alu u_alu (
    .op_i   (op_q),
    .a_i    (old_a),
    .b_i    (b_q),
    .swap_i (swap_q),
    .res_o  (alu_res)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    lane_d      = lane_q;
    b_d         = b_q;
    swap_d      = swap_q;
    rvalid_d    = 1'b0;
    rid_d       = rid_q;
    resp_sel_d  = RespConst;
    resp_data_d = '0;
    res_valid_d = res_valid_q;
    res_addr_d  = res_addr_q;
    wr_valid    = 1'b0;
    wr_addr     = bus.in_add_i;
    bus.in_gnt_o    = 1'b0;
    bus.out_req_o   = 1'b0;
    bus.out_add_o   = bus.in_add_i;
    bus.out_wen_o   = 1'b0;
    bus.out_wdata_o = bus.in_wdata_i;
    bus.out_be_o    = bus.in_be_i;
    if (state_q == StDoAmo) begin
      bus.out_req_o   = 1'b1;
      bus.out_add_o   = addr_q;
      bus.out_wen_o   = 1'b1;
      bus.out_be_o    = lane_be(lane_q);
      bus.out_wdata_o = lane_place(lane_q, alu_res);
      wr_valid        = 1'b1;
      wr_addr         = addr_q;
      state_d         = StIdle;
    end else begin
      bus.in_gnt_o = bus.in_req_i;
      if (bus.in_req_i) begin
        rvalid_d = 1'b1;
        rid_d    = bus.in_id_i;
        if (in_op == AMO_SC) begin
          res_valid_d[bus.in_id_i] = 1'b0;
          if (sc_ok) begin
            bus.out_req_o = 1'b1;
            bus.out_wen_o = 1'b1;
            bus.out_be_o  = lane_be(in_lane);
            wr_valid      = 1'b1;
          end else begin
            resp_data_d = lane_place(in_lane, 32'd1);
          end
        end else if (in_op == AMO_LR) begin
          bus.out_req_o = 1'b1;
          res_valid_d[bus.in_id_i] = 1'b1;
          res_addr_d[bus.in_id_i]  = bus.in_add_i;
          resp_sel_d = RespLoad;
        end else if (in_op != AMO_NONE) begin
          bus.out_req_o = 1'b1;
          bus.out_be_o  = '1;
          state_d    = StDoAmo;
          op_d       = in_op;
          addr_d     = bus.in_add_i;
          lane_d     = in_lane;
          b_d        = in_b;
          swap_d     = in_swap;
          resp_sel_d = RespAmo;
        end else begin
          bus.out_req_o = 1'b1;
          bus.out_wen_o = bus.in_wen_i;
          wr_valid      = bus.in_wen_i;
          if (!bus.in_wen_i) resp_sel_d = RespLoad;
        end
      end
    end
    // Any committed write kills every reservation on that word, the writer's included.
    if (wr_valid) begin
      for (int unsigned r = 0; r < NumResv; r++)
        if (res_addr_q[r] == wr_addr) res_valid_d[r] = 1'b0;
    end
  end

  always_comb begin
    bus.in_rvalid_o = rvalid_q;
    bus.in_rid_o    = rid_q;
    bus.dbg_state_o = state_q;
    case (resp_sel_q)
      RespLoad: bus.in_rdata_o = bus.out_rdata_i;
      RespAmo:  bus.in_rdata_o = lane_place(lane_q, old_a);
      default:  bus.in_rdata_o = resp_data_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      op_q        <= AMO_NONE;
      addr_q      <= '0;
      lane_q      <= '0;
      b_q         <= '0;
      swap_q      <= '0;
      rvalid_q    <= 1'b0;
      rid_q       <= '0;
      resp_sel_q  <= RespConst;
      resp_data_q <= '0;
      res_valid_q <= '0;
      res_addr_q  <= '{default: '0};
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      lane_q      <= lane_d;
      b_q         <= b_d;
      swap_q      <= swap_d;
      rvalid_q    <= rvalid_d;
      rid_q       <= rid_d;
      resp_sel_q  <= resp_sel_d;
      resp_data_q <= resp_data_d;
      res_valid_q <= res_valid_d;
      res_addr_q  <= res_addr_d;
    end
  end
endmodule

// File: tb/tb_tcdm_amo_lrsc_shim.sv
// Bench for tcdm_amo_lrsc_shim: directed scenarios plus random traffic against a word-level model.
module tb_tcdm_amo_lrsc_shim;
  import tcdm_amo_pkg::*;

  localparam int unsigned AW = 32, DW = 64, NC = 8, BEW = 8, DEPTH = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tcdm_amo_lrsc_shim_if #(.AddrMemWidth(AW), .DataWidth(DW), .NumCores(NC)) bus ();

  tcdm_amo_lrsc_shim #(.AddrMemWidth(AW), .DataWidth(DW), .NumCores(NC)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [63:0] seed(input int i);
    logic [31:0] x;
    x = 32'(i) * 32'h9E37_79B9;
    return {x, ~x};
  endfunction

  // ---------------- SRAM bank (environment) ----------------
  logic [DW-1:0] sram [DEPTH];
  bit            seeded;
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < DEPTH; i++) sram[i] <= seed(i);
      seeded <= 1'b1;
    end else if (bus.out_req_o) begin
      if (bus.out_wen_o) begin
        for (int i = 0; i < BEW; i++)
          if (bus.out_be_o[i]) sram[bus.out_add_o[5:0]][i*8 +: 8] <= bus.out_wdata_o[i*8 +: 8];
      end else begin
        bus.out_rdata_i <= sram[bus.out_add_o[5:0]];
      end
    end
  end

  // ---------------- reference model ----------------
  logic [63:0] mem_m [DEPTH];
  bit          res_v [NC];
  logic [31:0] res_a [NC];

  function automatic int low_lane(input logic [7:0] be);
    return (be[3:0] != 4'h0) ? 0 : ((be[7:4] != 4'h0) ? 1 : 0);
  endfunction

  task automatic invalidate(input logic [31:0] addr);
    for (int c = 0; c < NC; c++) if (res_a[c] == addr) res_v[c] = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] op, input logic [31:0] addr, input logic wen,
                            input logic [63:0] wd, input logic [7:0] be, input logic [2:0] id,
                            output logic [63:0] exp_d, output logic exp_req);
    int l;
    logic [3:0]  o;
    logic [31:0] a, b, s, r;
    logic [63:0] word;
    l    = low_lane(be);
    o    = (op > 4'hC) ? 4'h0 : op;
    word = mem_m[addr[5:0]];
    a    = word[l*32 +: 32];
    b    = wd[l*32 +: 32];
    s    = wd[(l ^ 1)*32 +: 32];
    exp_req = 1'b1;
    exp_d   = '0;
    if (o == 4'h0) begin
      if (wen) begin
        for (int i = 0; i < 8; i++) if (be[i]) word[i*8 +: 8] = wd[i*8 +: 8];
        mem_m[addr[5:0]] = word;
        invalidate(addr);
      end else exp_d = word;
    end else if (o == 4'hB) begin
      exp_d     = word;
      res_v[id] = 1'b1;
      res_a[id] = addr;
    end else if (o == 4'hC) begin
      if (res_v[id] && res_a[id] == addr) begin
        word[l*32 +: 32] = b;
        mem_m[addr[5:0]] = word;
        invalidate(addr);
      end else begin
        exp_req = 1'b0;
        exp_d   = 64'd1 << (32 * l);
      end
      res_v[id] = 1'b0;
    end else begin
      case (o)
        4'h1:    r = b;
        4'h2:    r = a + b;
        4'h3:    r = a & b;
        4'h4:    r = a | b;
        4'h5:    r = a ^ b;
        4'h6:    r = ($signed(a) > $signed(b)) ? a : b;
        4'h7:    r = (a > b) ? a : b;
        4'h8:    r = ($signed(a) < $signed(b)) ? a : b;
        4'h9:    r = (a < b) ? a : b;
        default: r = (a == b) ? s : a;
      endcase
      exp_d = 64'(a) << (32 * l);
      word[l*32 +: 32] = r;
      mem_m[addr[5:0]] = word;
      invalidate(addr);
    end
  endtask

  // ---------------- checking and driving ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] addr, input logic wen,
                       input logic [63:0] wd, input logic [7:0] be, input logic [2:0] id);
    bus.in_req_i   = 1'b1;
    bus.in_amo_i   = op;
    bus.in_add_i   = addr;
    bus.in_wen_i   = wen;
    bus.in_wdata_i = wd;
    bus.in_be_i    = be;
    bus.in_id_i    = id;
  endtask

  // One transaction; with follow set an AMO is chased by a load to the same word in the stall cycle.
  task automatic xact(input logic [3:0] op, input logic [31:0] addr, input logic wen,
                      input logic [63:0] wd, input logic [7:0] be, input logic [2:0] id,
                      input bit follow, output logic [63:0] got);
    logic [63:0] exp_d;
    logic        exp_req;
    int          w;
    bit          chase;
    chase = follow && (op >= 4'h1) && (op <= 4'hA);
    got   = '0;
    @(posedge clk); #1;
    drive(op, addr, wen, wd, be, id);
    @(negedge clk);
    w = 0;
    while (!bus.in_gnt_o && w < 8) begin w++; @(negedge clk); end
    check("gnt", bus.in_gnt_o, 1'b1);
    if (!bus.in_gnt_o) begin
      bus.in_req_i = 1'b0;
      return;
    end
    model_step(op, addr, wen, wd, be, id, exp_d, exp_req);
    check("out_req", bus.out_req_o, exp_req);
    @(posedge clk); #1;
    if (chase) drive(4'h0, addr, 1'b0, 64'h0, 8'hFF, id);
    else bus.in_req_i = 1'b0;
    @(negedge clk);
    got = bus.in_rdata_o;
    check("rvalid", bus.in_rvalid_o, 1'b1);
    check("rid", bus.in_rid_o, id);
    check("rdata", got, exp_d);
    if (chase) begin
      check("gnt_stall", bus.in_gnt_o, 1'b0);
      @(negedge clk);
      check("gnt_after_amo", bus.in_gnt_o, 1'b1);
      model_step(4'h0, addr, 1'b0, 64'h0, 8'hFF, id, exp_d, exp_req);
      @(posedge clk); #1;
      bus.in_req_i = 1'b0;
      @(negedge clk);
      check("chase_rdata", bus.in_rdata_o, exp_d);
    end
  endtask

  task automatic settle();
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    logic [63:0] got, wd;
    logic [3:0]  op, prev_op;
    logic [31:0] addr, prev_addr;
    logic [2:0]  id, prev_id;
    logic [7:0]  be;
    logic        wen;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = seed(i);
    for (int c = 0; c < NC; c++) begin res_v[c] = 1'b0; res_a[c] = '0; end
    bus.in_req_i = 1'b0; bus.in_amo_i = '0; bus.in_add_i = '0; bus.in_wen_i = 1'b0;
    bus.in_wdata_i = '0; bus.in_be_i = '0; bus.in_id_i = '0;

    repeat (2) @(negedge clk);
    check("rst_rvalid", bus.in_rvalid_o, 1'b0);
    check("rst_rid", bus.in_rid_o, 3'd0);
    check("rst_rdata", bus.in_rdata_o, 64'h0);
    check("rst_state", bus.dbg_state_o, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;

    // AMOAdd on the upper lane
    xact(4'h0, 32'h10, 1'b1, 64'h00000005_FFFFFFFE, 8'hFF, 3'd0, 1'b0, got);
    xact(4'h2, 32'h10, 1'b0, 64'h00000003_12345678, 8'hF0, 3'd0, 1'b1, got);
    check("add_resp", got, 64'h00000005_00000000);
    settle();
    check("add_mem", sram[6'h10], 64'h00000008_FFFFFFFE);

    // signed vs unsigned max
    xact(4'h0, 32'h11, 1'b1, 64'h00000000_FFFFFFFE, 8'hFF, 3'd0, 1'b0, got);
    xact(4'h6, 32'h11, 1'b0, 64'h00000000_00000001, 8'h0F, 3'd0, 1'b0, got);
    check("max_resp", got, 64'h00000000_FFFFFFFE);
    settle();
    check("max_mem", sram[6'h11], 64'h00000000_00000001);
    xact(4'h0, 32'h11, 1'b1, 64'h00000000_FFFFFFFE, 8'hFF, 3'd0, 1'b0, got);
    xact(4'h7, 32'h11, 1'b0, 64'h00000000_00000001, 8'h0F, 3'd0, 1'b0, got);
    check("maxu_resp", got, 64'h00000000_FFFFFFFE);
    settle();
    check("maxu_mem", sram[6'h11], 64'h00000000_FFFFFFFE);

    // LR/SC success then a repeated SC fails
    xact(4'hB, 32'h20, 1'b0, 64'h0, 8'hFF, 3'd2, 1'b0, got);
    xact(4'hC, 32'h20, 1'b0, 64'h7, 8'h0F, 3'd2, 1'b0, got);
    check("sc_ok_resp", got, 64'h0);
    settle();
    check("sc_ok_mem", sram[6'h20][31:0], 32'h7);
    xact(4'hC, 32'h20, 1'b0, 64'h9, 8'h0F, 3'd2, 1'b0, got);
    check("sc_again_resp", got, 64'h1);

    // another core's store kills the reservation
    xact(4'hB, 32'h20, 1'b0, 64'h0, 8'hFF, 3'd1, 1'b0, got);
    xact(4'h0, 32'h20, 1'b1, 64'h33333333_CAFE0003, 8'hFF, 3'd3, 1'b0, got);
    xact(4'hC, 32'h20, 1'b0, 64'h11, 8'h0F, 3'd1, 1'b0, got);
    check("sc_inval_resp", got, 64'h1);
    settle();
    check("sc_inval_mem", sram[6'h20], 64'h33333333_CAFE0003);

    // CAS hit then miss
    xact(4'h0, 32'h28, 1'b1, 64'h9, 8'hFF, 3'd0, 1'b0, got);
    xact(4'hA, 32'h28, 1'b0, 64'h000000AA_00000009, 8'h0F, 3'd0, 1'b0, got);
    check("cas_hit_resp", got, 64'h9);
    settle();
    check("cas_hit_mem", sram[6'h28], 64'hAA);
    xact(4'hA, 32'h28, 1'b0, 64'h000000AA_00000009, 8'h0F, 3'd0, 1'b0, got);
    check("cas_miss_resp", got, 64'hAA);
    settle();
    check("cas_miss_mem", sram[6'h28], 64'hAA);

    // reset while the AMO write is pending
    xact(4'h0, 32'h30, 1'b1, 64'h00000000_00000064, 8'hFF, 3'd0, 1'b0, got);
    xact(4'hB, 32'h30, 1'b0, 64'h0, 8'hFF, 3'd4, 1'b0, got);
    @(posedge clk); #1;
    drive(4'h2, 32'h30, 1'b0, 64'h1, 8'h0F, 3'd5);
    @(negedge clk);
    check("rst_amo_gnt", bus.in_gnt_o, 1'b1);
    @(posedge clk); #1;
    bus.in_req_i = 1'b0;
    rst_n = 1'b0;
    for (int c = 0; c < NC; c++) res_v[c] = 1'b0;
    @(negedge clk);
    check("rst_amo_rvalid", bus.in_rvalid_o, 1'b0);
    check("rst_amo_req", bus.out_req_o, 1'b0);
    check("rst_amo_state", bus.dbg_state_o, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    xact(4'hC, 32'h30, 1'b0, 64'h5, 8'h0F, 3'd4, 1'b0, got);
    check("rst_sc_resp", got, 64'h1);
    xact(4'h0, 32'h30, 1'b0, 64'h0, 8'hFF, 3'd0, 1'b0, got);
    check("rst_mem_kept", got, 64'h00000000_00000064);

    // random traffic on a few words so reservations collide
    prev_op = 4'h0; prev_addr = '0; prev_id = '0;
    for (int k = 0; k < 400; k++) begin
      op   = 4'($urandom_range(0, 15));
      addr = 32'($urandom_range(0, 7));
      id   = 3'($urandom_range(0, 7));
      wen  = 1'($urandom_range(0, 1));
      wd   = {$urandom, $urandom};
      be   = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      if (prev_op == 4'hB && $urandom_range(0, 1) == 1) begin
        op = 4'hC; addr = prev_addr; id = prev_id;
      end
      if (op == 4'hA && $urandom_range(0, 1) == 1)
        wd[low_lane(be)*32 +: 32] = mem_m[addr[5:0]][low_lane(be)*32 +: 32];
      xact(op, addr, wen, wd, be, id, bit'($urandom_range(0, 1)), got);
      prev_op = op; prev_addr = addr; prev_id = id;
    end
    settle();
    for (int i = 0; i < DEPTH; i++) check("final_mem", sram[i], mem_m[i]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
